dmux4way16_dispatch: RTL and testbench
======================================

// Module: dmux4way16_dispatch
// PURPOSE
//   Inverse of the 4-way 16-bit selector: routes one input word stream to one of four output channels (a..d) by sel.
//   Each channel has its own small FIFO and valid/ready handshake, so a stalled channel never blocks the others.
//   Sits between a single producer (e.g. a bus or ALU result path) and four independent consumers.
// PARAMETERS
//   WIDTH  16  data word width in bits
//   DEPTH  2   entries per channel FIFO; power of two, >= 2
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous reset, active-low
//   in_valid     in   1      input word present
//   in_ready     out  1      dispatcher accepts the input word this cycle
//   in_data      in   WIDTH  input word
//   in_sel       in   2      destination: 00=a, 01=b, 10=c, 11=d
//   out_X_valid  out  1      channel X (X=a,b,c,d) holds a word; 4 ports
//   out_X_ready  in   1      channel X consumer takes the word; 4 ports
//   out_X_data   out  WIDTH  channel X head word; 4 ports
//   drop_cnt     out  8      saturating count of cycles with in_valid=1 and in_ready=0
// BEHAVIOUR
//   Reset (rst_n low, async): all FIFOs empty, all out_X_valid=0, out_X_data=0, drop_cnt=0. in_ready=0 while rst_n=0.
//   Accept: a push occurs when in_valid && in_ready. The word is written to the FIFO selected by in_sel at that clock edge.
//   in_ready = (count[in_sel] < DEPTH). It is combinational from in_sel and registered counts only, never from out_X_ready.
//   Full channel: when count==DEPTH, in_ready=0 for that sel, even if the same channel pops this cycle. No ready-to-ready comb path.
//   Latency: a pushed word appears on out_X_valid/out_X_data the next cycle (1 clk). There is no bypass from in_data to the outputs.
//   Pop: channel X pops when out_X_valid && out_X_ready. The head advances at the edge.
//   Simultaneous push+pop on the same non-full channel: the count is unchanged and order is preserved.
//   Non-empty channels pop independently in the same cycle.
//   Ordering: FIFO order holds per channel. There is no ordering guarantee across channels.
//   Pointers wrap modulo DEPTH. count is clog2(DEPTH)+1 bits wide, range 0..DEPTH.
//   out_X_data is the head entry when valid. When the FIFO is empty it holds the last popped value; consumers must ignore it when valid=0.
//   in_valid=1 and in_sel changing while in_ready=0 is legal. in_sel is sampled only when a push occurs.
//   drop_cnt increments once per stalled-input cycle and saturates at 255 (no wrap).
//   Reset mid-operation: contents are discarded immediately and valids drop asynchronously.
//   The first push after release is accepted on the first rising edge with rst_n=1.
//   No X propagation: in_data is not stored unless a push occurs.
// STRUCTURE
//   Shared header hack_defs.vh holds localparams SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
//   The mux4way16 blocks include the same header so both directions share one encoding.
//   Sub-module chan_fifo (WIDTH, DEPTH) has ports clk, rst_n, push, push_data, pop, valid, head, count.
//   It is instantiated four times. The top module holds sel decode, in_ready mux and drop_cnt only.
// TESTING
//   1. Reset, then push 16'h00AA sel=00, 16'h00BB sel=01, 16'h00CC sel=10, 16'h00DD sel=11 with all out ready.
//      -> each word appears on a,b,c,d respectively one cycle after its push.
//   2. out_b_ready=0; push 16'h1111, 16'h2222, 16'h3333 to sel=01.
//      -> first two accepted, third sees in_ready=0, drop_cnt increments each stall cycle.
//      -> raise ready: b drains 1111 then 2222, then 3333 is accepted.
//   3. Channel a full with out_a_ready=1 and push to a in the same cycle.
//      -> in_ready=0 that cycle, pop still occurs, push is accepted the next cycle.
//   4. Channel c stalled full; stream to a, b, d.
//      -> no stall on those channels, all words are delivered in order.
//   5. Hold in_valid=1 with a full target for 300 cycles.
//      -> drop_cnt saturates at 8'd255.
//   6. Assert rst_n=0 mid-stream with words in all FIFOs.
//      -> all out_X_valid=0 immediately (before next edge), drop_cnt=0.
//      -> post-release push to d appears 1 cycle later.

Source files
------------

// File: rtl/dmux4way16_dispatch_pkg.sv
// Shared definitions for the 4-way 16-bit dispatcher.
// Contents:
//   SEL_A..SEL_D : channel select encoding, shared with the mux4way16 direction
//   SelW         : width of the select field
//   NumChan      : number of output channels
//   sel_decode() : 2-bit select to one-hot channel vector
package dmux4way16_dispatch_pkg;

    localparam int unsigned SelW    = 2;
    localparam int unsigned NumChan = 4;

    localparam logic [SelW-1:0] SEL_A = 2'b00;
    localparam logic [SelW-1:0] SEL_B = 2'b01;
    localparam logic [SelW-1:0] SEL_C = 2'b10;
    localparam logic [SelW-1:0] SEL_D = 2'b11;

    function automatic logic [NumChan-1:0] sel_decode(input logic [SelW-1:0] sel);
        logic [NumChan-1:0] onehot;
        onehot = '0;
        unique case (sel)
            SEL_A:   onehot = 4'b0001;
            SEL_B:   onehot = 4'b0010;
            SEL_C:   onehot = 4'b0100;
            SEL_D:   onehot = 4'b1000;
            default: onehot = '0;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/dmux4way16_dispatch_if.sv
// Handshake bundle of the dispatcher: one producer-side input stream, four
// consumer-side output channels (a..d) and the drop counter.
// Modports:
//   slave  : the dispatcher (consumes in_*, drives out_*_valid/data, drop_cnt)
//   master : the environment (drives in_* and out_*_ready)
interface dmux4way16_dispatch_if
    import dmux4way16_dispatch_pkg::*;
#(
    parameter int unsigned WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SelW-1:0]  in_sel;

    logic             out_a_valid;
    logic             out_a_ready;
    logic [WIDTH-1:0] out_a_data;
    logic             out_b_valid;
    logic             out_b_ready;
    logic [WIDTH-1:0] out_b_data;
    logic             out_c_valid;
    logic             out_c_ready;
    logic [WIDTH-1:0] out_c_data;
    logic             out_d_valid;
    logic             out_d_ready;
    logic [WIDTH-1:0] out_d_data;

    logic [7:0]       drop_cnt;

    modport slave (
        input  in_valid, in_data, in_sel,
        input  out_a_ready, out_b_ready, out_c_ready, out_d_ready,
        output in_ready,
        output out_a_valid, out_a_data, out_b_valid, out_b_data,
        output out_c_valid, out_c_data, out_d_valid, out_d_data,
        output drop_cnt
    );

    modport master (
        output in_valid, in_data, in_sel,
        output out_a_ready, out_b_ready, out_c_ready, out_d_ready,
        input  in_ready,
        input  out_a_valid, out_a_data, out_b_valid, out_b_data,
        input  out_c_valid, out_c_data, out_d_valid, out_d_data,
        input  drop_cnt
    );

endinterface

// File: rtl/dmux4way16_dispatch_chan_fifo.sv
// Per-channel FIFO of the dispatcher.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full)
//   push_data   : word to write
//   pop         : consumer takes the head (ignored when empty)
//   valid       : FIFO holds at least one word
//   head        : head word when valid, otherwise the last popped word
//   count       : number of stored words, 0..DEPTH
module chan_fifo #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [CntW-1:0]  count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             do_push, do_pop;

    always_comb begin
        // Full blocks a push even when a pop happens in the same cycle.
        do_push  = push && (count_q < CntW'(DEPTH));
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            // DEPTH is a power of two, so pointers wrap by overflow.
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            last_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    assign valid = (count_q != '0);
    assign head  = valid ? mem_q[rd_ptr_q] : last_q;
    assign count = count_q;

endmodule

// File: rtl/dmux4way16_dispatch.sv
// Routes a single input word stream to one of four output channels (a..d)
// chosen by in_sel. Each channel buffers in its own FIFO so a stalled
// consumer never blocks the other channels.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous reset, active-low
//   bus    : slave side of dmux4way16_dispatch_if (input stream, four output
//            channels, saturating drop_cnt of stalled input cycles)
module dmux4way16_dispatch
    import dmux4way16_dispatch_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dmux4way16_dispatch_if.slave        bus
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [NumChan-1:0] push_vec;
    logic [NumChan-1:0] pop_vec;
    logic [NumChan-1:0] valid_vec;
    logic [WIDTH-1:0]   head_vec [NumChan];
    logic [CntW-1:0]    cnt_vec  [NumChan];
    logic               in_ready;
    logic [7:0]         drop_q, drop_d;

    always_comb begin
        // Only registered counts feed in_ready; consumer ready never does.
        in_ready = rst_n && (cnt_vec[bus.in_sel] < CntW'(DEPTH));
        push_vec = (bus.in_valid && in_ready) ? sel_decode(bus.in_sel) : '0;
        pop_vec  = {bus.out_d_ready, bus.out_c_ready, bus.out_b_ready, bus.out_a_ready};

        drop_d = drop_q;
        if (bus.in_valid && !in_ready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    for (genvar i = 0; i < int'(NumChan); i++) begin : gen_chan
        chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_chan_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_vec[i]),
            .push_data (bus.in_data),
            .pop       (pop_vec[i]),
            .valid     (valid_vec[i]),
            .head      (head_vec[i]),
            .count     (cnt_vec[i])
        );
    end

    assign bus.in_ready    = in_ready;
    assign bus.drop_cnt    = drop_q;
    assign bus.out_a_valid = valid_vec[0];
    assign bus.out_b_valid = valid_vec[1];
    assign bus.out_c_valid = valid_vec[2];
    assign bus.out_d_valid = valid_vec[3];
    assign bus.out_a_data  = head_vec[0];
    assign bus.out_b_data  = head_vec[1];
    assign bus.out_c_data  = head_vec[2];
    assign bus.out_d_data  = head_vec[3];

endmodule

// File: tb/tb_dmux4way16_dispatch.sv
module tb_dmux4way16_dispatch;
    import dmux4way16_dispatch_pkg::*;

    localparam int Depth = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmux4way16_dispatch_if #(.WIDTH(16)) bus();

    dmux4way16_dispatch #(
        .WIDTH (16),
        .DEPTH (Depth)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0]  rdy;
    logic [3:0]  ov;
    logic [15:0] od [4];

    assign bus.out_a_ready = rdy[0];
    assign bus.out_b_ready = rdy[1];
    assign bus.out_c_ready = rdy[2];
    assign bus.out_d_ready = rdy[3];
    assign ov    = {bus.out_d_valid, bus.out_c_valid, bus.out_b_valid, bus.out_a_valid};
    assign od[0] = bus.out_a_data;
    assign od[1] = bus.out_b_data;
    assign od[2] = bus.out_c_data;
    assign od[3] = bus.out_d_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef logic [15:0] word_q_t[$];
    word_q_t sb [4];
    int      drop_mdl = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expectations pushed on accepted input, popped on output handshake.
    always @(negedge clk) begin
        logic exp_rdy;
        if (!rst_n) begin
            chk("rst_valid", {28'd0, ov}, 32'd0);
            chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("rst_drop", {24'd0, bus.drop_cnt}, 32'd0);
            for (int c = 0; c < 4; c++) sb[c].delete();
            drop_mdl = 0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                chk("sb_valid", {31'd0, ov[c]}, {31'd0, sb[c].size() != 0});
                if (ov[c] && sb[c].size() != 0) chk("sb_data", {16'd0, od[c]}, {16'd0, sb[c][0]});
            end
            exp_rdy = (sb[bus.in_sel].size() < Depth);
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
            chk("drop_cnt", {24'd0, bus.drop_cnt}, drop_mdl);
            for (int c = 0; c < 4; c++) begin
                if (ov[c] && rdy[c] && sb[c].size() != 0) void'(sb[c].pop_front());
            end
            if (bus.in_valid && exp_rdy) sb[bus.in_sel].push_back(bus.in_data);
            if (bus.in_valid && !exp_rdy && drop_mdl < 255) drop_mdl++;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic push(input logic [1:0] s, input logic [15:0] d, output int stalls);
        stalls = 0;
        bus.in_valid = 1'b1;
        bus.in_sel   = s;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && stalls < 400) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: sel %0d never ready, required ready within 400 cycles", s);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  exp_valid;
    } vec_t;

    vec_t        tbl [4];
    logic [1:0]  stream_sel [3];
    int          st;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sel   = SEL_A;
        bus.in_data  = '0;
        rdy          = 4'hF;
        tbl[0] = '{SEL_A, 16'h00AA, 4'b0001};
        tbl[1] = '{SEL_B, 16'h00BB, 4'b0010};
        tbl[2] = '{SEL_C, 16'h00CC, 4'b0100};
        tbl[3] = '{SEL_D, 16'h00DD, 4'b1000};
        stream_sel[0] = SEL_A;
        stream_sel[1] = SEL_B;
        stream_sel[2] = SEL_D;

        @(negedge clk);
        chk("reset_data_a", {16'd0, od[0]}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: one word per channel, visible exactly one cycle after push.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = tbl[i].sel;
            bus.in_data  = tbl[i].data;
            @(negedge clk);
            chk("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
            chk("t1_not_yet", {28'd0, ov}, 32'd0);
            next_cycle();
            bus.in_valid = 1'b0;
            @(negedge clk);
            chk("t1_valid", {28'd0, ov}, {28'd0, tbl[i].exp_valid});
            chk("t1_data", {16'd0, od[tbl[i].sel]}, {16'd0, tbl[i].data});
            next_cycle();
        end

        // 2: channel b stalls; third word waits until b drains.
        rdy[1] = 1'b0;
        push(SEL_B, 16'h1111, st);
        chk("t2_stall0", st, 0);
        push(SEL_B, 16'h2222, st);
        chk("t2_stall1", st, 0);
        bus.in_valid = 1'b1;
        bus.in_sel   = SEL_B;
        bus.in_data  = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_full", {31'd0, bus.in_ready}, 32'd0);
            next_cycle();
        end
        rdy[1] = 1'b1;
        @(negedge clk);
        chk("t2_no_ready_path", {31'd0, bus.in_ready}, 32'd0);
        chk("t2_head0", {16'd0, od[1]}, 32'h1111);
        next_cycle();
        @(negedge clk);
        chk("t2_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
        chk("t2_head1", {16'd0, od[1]}, 32'h2222);
        chk("t2_drop", {24'd0, bus.drop_cnt}, 32'd4);
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t2_head2", {16'd0, od[1]}, 32'h3333);
        repeat (3) next_cycle();

        // 3: full channel a, pop and push in the same cycle.
        rdy[0] = 1'b0;
        push(SEL_A, 16'hA001, st);
        push(SEL_A, 16'hA002, st);
        rdy[0] = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel   = SEL_A;
        bus.in_data  = 16'hA003;
        @(negedge clk);
        chk("t3_full_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t3_a_valid", {31'd0, ov[0]}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("t3_ready_next", {31'd0, bus.in_ready}, 32'd1);
        chk("t3_head", {16'd0, od[0]}, 32'hA002);
        next_cycle();
        bus.in_valid = 1'b0;
        repeat (4) next_cycle();

        // 4: channel c stalled full; other channels keep streaming.
        rdy[2] = 1'b0;
        push(SEL_C, 16'hC001, st);
        push(SEL_C, 16'hC002, st);
        for (int i = 0; i < 6; i++) begin
            push(stream_sel[i % 3], 16'h4000 + 16'(i), st);
            chk("t4_no_stall", st, 0);
        end
        rdy[2] = 1'b1;
        repeat (4) next_cycle();

        // 5: drop counter saturates.
        rdy[1] = 1'b0;
        push(SEL_B, 16'hB001, st);
        push(SEL_B, 16'hB002, st);
        bus.in_valid = 1'b1;
        bus.in_sel   = SEL_B;
        bus.in_data  = 16'hB003;
        repeat (300) next_cycle();
        @(negedge clk);
        chk("t5_drop_sat", {24'd0, bus.drop_cnt}, 32'd255);
        next_cycle();
        bus.in_valid = 1'b0;

        // 6: asynchronous reset with words in every FIFO.
        rdy = 4'h0;
        push(SEL_A, 16'h6A6A, st);
        push(SEL_C, 16'h6C6C, st);
        push(SEL_D, 16'h6D6D, st);
        chk("t6_pre_valid", {28'd0, ov}, 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {28'd0, ov}, 32'd0);
        chk("t6_async_drop", {24'd0, bus.drop_cnt}, 32'd0);
        chk("t6_async_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t6_async_data", {16'd0, od[3]}, 32'd0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel   = SEL_D;
        bus.in_data  = 16'hDEAD;
        @(negedge clk);
        chk("t6_first_ready", {31'd0, bus.in_ready}, 32'd1);
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_d_valid", {28'd0, ov}, 32'h8);
        chk("t6_d_data", {16'd0, od[3]}, 32'hDEAD);
        next_cycle();
        rdy = 4'hF;
        repeat (3) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
